// File: rtl/y86_fetch_stage.sv
// Y86-64 fetch stage: PC select, instruction memory, decode/predict, F and D registers.
// Optional stall/bubble controls are enabled by defining FETCH_STALL_BUBBLE_EN.
module y86_fetch_stage #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rstn_i,
`ifdef FETCH_STALL_BUBBLE_EN
  input  logic        F_stall_i,
  input  logic        D_stall_i,
  input  logic        D_bubble_i,
`endif
  input  logic        imem_we_i,
  input  logic [63:0] imem_waddr_i,
  input  logic [7:0]  imem_wdata_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_Cnd_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  W_icode_i,
  input  logic [63:0] W_valM_i,
  output logic [63:0] F_pred_pc_o,
  output logic [63:0] f_pred_pc_o,
  output logic [3:0]  D_icode_o,
  output logic [3:0]  D_ifun_o,
  output logic [3:0]  D_rA_o,
  output logic [3:0]  D_rB_o,
  output logic [63:0] D_valC_o,
  output logic [63:0] D_valP_o,
  output logic [3:0]  D_stat_o
);

  localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
                         I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
                         I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [3:0] S_AOK = 4'h1, S_HLT = 4'h2, S_ADR = 4'h3, S_INS = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

  logic [7:0]  r_imem [IMEM_BYTES];

  logic [63:0] r_F_pred_pc;
  logic [3:0]  r_D_icode, r_D_ifun, r_D_rA, r_D_rB, r_D_stat;
  logic [63:0] r_D_valC, r_D_valP;

  logic [63:0] w_pc;
  logic [7:0]  w_bytes [10];
  logic [3:0]  w_raw_icode;
  logic        w_need_regids, w_need_valC, w_imem_error;
  logic [3:0]  w_len;
  logic [63:0] w_raw_valC;
  logic [3:0]  w_icode, w_ifun, w_rA, w_rB, w_stat;
  logic [63:0] w_valC, w_valP, w_pred_pc;
  logic        w_f_load, w_d_load, w_d_bubble;

  always_ff @(posedge clk_i) begin
    if (imem_we_i && (imem_waddr_i < 64'(IMEM_BYTES)))
      r_imem[imem_waddr_i[AW-1:0]] <= imem_wdata_i;
  end

  function automatic logic [7:0] rd_byte(input logic [63:0] addr);
    // Bytes past the end read as zero; the length check flags the fetch anyway.
    if (addr < 64'(IMEM_BYTES)) rd_byte = r_imem[addr[AW-1:0]];
    else                        rd_byte = 8'h00;
  endfunction

  always_comb begin
    if (M_icode_i == I_JXX && !M_Cnd_i) w_pc = M_valA_i;
    else if (W_icode_i == I_RET)        w_pc = W_valM_i;
    else                                w_pc = r_F_pred_pc;
  end

  always_comb begin
    for (int k = 0; k < 10; k++) w_bytes[k] = rd_byte(w_pc + 64'(k));
  end

  always_comb begin
    w_raw_icode   = w_bytes[0][7:4];
    w_need_regids = w_raw_icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                                        I_OPQ, I_PUSHQ, I_POPQ};
    w_need_valC   = w_raw_icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
    w_len         = 4'd1 + {3'b000, w_need_regids} + (w_need_valC ? 4'd8 : 4'd0);
    // 65-bit sum so an instruction straddling 2^64 cannot wrap past the check.
    w_imem_error  = ({1'b0, w_pc} + 65'(w_len)) > 65'(IMEM_BYTES);
    w_valP        = w_pc + 64'(w_len);

    w_raw_valC = '0;
    for (int k = 0; k < 8; k++)
      w_raw_valC[8*k +: 8] = w_need_regids ? w_bytes[k+2] : w_bytes[k+1];

    w_icode = w_raw_icode;
    w_ifun  = w_bytes[0][3:0];
    w_rA    = w_need_regids ? w_bytes[1][7:4] : R_NONE;
    w_rB    = w_need_regids ? w_bytes[1][3:0] : R_NONE;
    w_valC  = w_need_valC ? w_raw_valC : 64'h0;
    if (w_imem_error) begin
      w_icode = I_NOP;
      w_ifun  = 4'h0;
      w_rA    = R_NONE;
      w_rB    = R_NONE;
      w_valC  = 64'h0;
    end

    if (w_imem_error)          w_stat = S_ADR;
    else if (w_raw_icode > I_POPQ) w_stat = S_INS;
    else if (w_raw_icode == I_HALT) w_stat = S_HLT;
    else                       w_stat = S_AOK;

    w_pred_pc = (w_icode == I_JXX || w_icode == I_CALL) ? w_valC : w_valP;
  end

  always_comb begin
    w_f_load   = 1'b1;
    w_d_load   = 1'b1;
    w_d_bubble = 1'b0;
`ifdef FETCH_STALL_BUBBLE_EN
    w_f_load   = !F_stall_i;
    w_d_load   = !D_stall_i;
    w_d_bubble = D_bubble_i && !D_stall_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       r_F_pred_pc <= 64'h0;
    else if (w_f_load) r_F_pred_pc <= w_pred_pc;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i || w_d_bubble) begin
      r_D_icode <= I_NOP;
      r_D_ifun  <= 4'h0;
      r_D_rA    <= R_NONE;
      r_D_rB    <= R_NONE;
      r_D_valC  <= 64'h0;
      r_D_valP  <= 64'h0;
      r_D_stat  <= S_AOK;
    end else if (w_d_load) begin
      r_D_icode <= w_icode;
      r_D_ifun  <= w_ifun;
      r_D_rA    <= w_rA;
      r_D_rB    <= w_rB;
      r_D_valC  <= w_valC;
      r_D_valP  <= w_valP;
      r_D_stat  <= w_stat;
    end
  end

  assign F_pred_pc_o = r_F_pred_pc;
  assign f_pred_pc_o = w_pred_pc;
  assign D_icode_o   = r_D_icode;
  assign D_ifun_o    = r_D_ifun;
  assign D_rA_o      = r_D_rA;
  assign D_rB_o      = r_D_rB;
  assign D_valC_o    = r_D_valC;
  assign D_valP_o    = r_D_valP;
  assign D_stat_o    = r_D_stat;

endmodule

// File: tb/tb_y86_fetch_stage.sv
// Directed bench for y86_fetch_stage: expected D/F values are queued per step and checked after each edge.
module tb_y86_fetch_stage;
  localparam int IMEM = 1024;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        imem_we_i;
  logic [63:0] imem_waddr_i;
  logic [7:0]  imem_wdata_i;
  logic [3:0]  M_icode_i, W_icode_i;
  logic        M_Cnd_i;
  logic [63:0] M_valA_i, W_valM_i;
  logic [63:0] F_pred_pc_o, f_pred_pc_o, D_valC_o, D_valP_o;
  logic [3:0]  D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_stat_o;

  y86_fetch_stage #(.IMEM_BYTES(IMEM)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .imem_we_i(imem_we_i), .imem_waddr_i(imem_waddr_i), .imem_wdata_i(imem_wdata_i),
    .M_icode_i(M_icode_i), .M_Cnd_i(M_Cnd_i), .M_valA_i(M_valA_i),
    .W_icode_i(W_icode_i), .W_valM_i(W_valM_i),
    .F_pred_pc_o(F_pred_pc_o), .f_pred_pc_o(f_pred_pc_o),
    .D_icode_o(D_icode_o), .D_ifun_o(D_ifun_o), .D_rA_o(D_rA_o), .D_rB_o(D_rB_o),
    .D_valC_o(D_valC_o), .D_valP_o(D_valP_o), .D_stat_o(D_stat_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [3:0]  icode, ifun, rA, rB, stat;
    logic [63:0] valC, valP, fpred;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] ic, input logic [3:0] ifn,
                      input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                      input logic [63:0] vp, input logic [3:0] st, input logic [63:0] fp);
    exp_t e;
    e.tag = tag; e.icode = ic; e.ifun = ifn; e.rA = ra; e.rB = rb;
    e.valC = vc; e.valP = vp; e.stat = st; e.fpred = fp;
    sb.push_back(e);
  endtask

  task automatic check_d();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".icode"}, 64'(D_icode_o), 64'(e.icode));
    chk({e.tag, ".ifun"},  64'(D_ifun_o),  64'(e.ifun));
    chk({e.tag, ".rA"},    64'(D_rA_o),    64'(e.rA));
    chk({e.tag, ".rB"},    64'(D_rB_o),    64'(e.rB));
    chk({e.tag, ".valC"},  D_valC_o,       e.valC);
    chk({e.tag, ".valP"},  D_valP_o,       e.valP);
    chk({e.tag, ".stat"},  64'(D_stat_o),  64'(e.stat));
    chk({e.tag, ".Fpc"},   F_pred_pc_o,    e.fpred);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    imem_we_i = 1'b1; imem_waddr_i = a; imem_wdata_i = d;
    step();
    imem_we_i = 1'b0;
  endtask

  task automatic ctl(input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                     input logic [3:0] wi, input logic [63:0] wm);
    M_icode_i = mi; M_Cnd_i = mc; M_valA_i = ma; W_icode_i = wi; W_valM_i = wm;
  endtask

  initial begin
    rstn_i = 1'b1; imem_we_i = 1'b0; imem_waddr_i = '0; imem_wdata_i = '0;
    ctl(4'h6, 1'b1, 64'h0, 4'h6, 64'h0);
    #1 rstn_i = 1'b0;

    // Program image, loaded while in reset.
    wr(0, 8'h30); wr(1, 8'hF3); wr(2, 8'h0A);
    for (int k = 3; k < 10; k++) wr(64'(k), 8'h00);
    wr(10, 8'h70); wr(11, 8'h40);
    for (int k = 12; k < 19; k++) wr(64'(k), 8'h00);
    wr(64'h40, 8'h60); wr(64'h41, 8'h23);
    wr(64'h20, 8'h10); wr(64'h30, 8'h00); wr(64'h50, 8'hF0); wr(64'h51, 8'h10);
    wr(64'h60, 8'h80); wr(64'h61, 8'h70);
    for (int k = 8'h62; k < 8'h69; k++) wr(64'(k), 8'h00);
    wr(1014, 8'h30); wr(1015, 8'hF1);
    wr(1016, 8'h01); wr(1017, 8'h02); wr(1018, 8'h03); wr(1019, 8'h04);
    wr(1020, 8'h05); wr(1021, 8'h06); wr(1022, 8'h30); wr(1023, 8'h08);
    wr(64'(IMEM), 8'h70);

    push("reset", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 4'h1, 64'h0);
    check_d();

    rstn_i = 1'b1;
    #1 chk("irmovq_fpred", f_pred_pc_o, 64'd10);
    push("irmovq", 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd10, 4'h1, 64'd10);
    step(); check_d();

    chk("jxx_fpred", f_pred_pc_o, 64'h40);
    push("jxx", 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'd19, 4'h1, 64'h40);
    step(); check_d();

    push("opq", 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h42, 4'h1, 64'h42);
    step(); check_d();

    ctl(4'h7, 1'b0, 64'h20, 4'h6, 64'h0);
    push("mispredict", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 4'h1, 64'h21);
    step(); check_d();

    ctl(4'h6, 1'b0, 64'h0, 4'h9, 64'h30);
    push("ret_halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h31, 4'h2, 64'h31);
    step(); check_d();

    ctl(4'h7, 1'b0, 64'h50, 4'h9, 64'h30);
    push("prio_ins", 4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 4'h4, 64'h51);
    step(); check_d();

    ctl(4'h7, 1'b1, 64'h20, 4'h6, 64'h0);
    push("jxx_taken_no_ovr", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h52, 4'h1, 64'h52);
    step(); check_d();

    ctl(4'h7, 1'b0, 64'h60, 4'h6, 64'h0);
    push("call", 4'h8, 4'h0, 4'hF, 4'hF, 64'h70, 64'h69, 4'h1, 64'h70);
    step(); check_d();

    ctl(4'h7, 1'b0, 64'd1014, 4'h6, 64'h0);
    push("edge_fit", 4'h3, 4'h0, 4'hF, 4'h1, 64'h0830060504030201, 64'd1024, 4'h1, 64'd1024);
    step(); check_d();

    ctl(4'h6, 1'b0, 64'h0, 4'h6, 64'h0);
    push("past_end", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1025, 4'h3, 64'd1025);
    step(); check_d();

    ctl(4'h7, 1'b0, 64'(IMEM - 2), 4'h6, 64'h0);
    push("straddle", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1032, 4'h3, 64'd1032);
    step(); check_d();

    #2 rstn_i = 1'b0;
    #1;
    push("async_rst", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 4'h1, 64'h0);
    check_d();

    ctl(4'h6, 1'b0, 64'h0, 4'h6, 64'h0);
    rstn_i = 1'b1;
    push("refetch0", 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd10, 4'h1, 64'd10);
    step(); check_d();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
